// File: rtl/flit_pkg.sv
// Shared flit encodings, port indices and demux FSM states for the 1x3 flit demultiplexer.
package flit_pkg;

    localparam logic [1:0] FT_HEAD = 2'b00;
    localparam logic [1:0] FT_TAIL = 2'b11;

    // Head destination encodings double as output port indices.
    localparam logic [1:0] DEST_A   = 2'b00;
    localparam logic [1:0] DEST_B   = 2'b01;
    localparam logic [1:0] DEST_C   = 2'b10;
    localparam logic [1:0] DEST_INV = 2'b11;

    localparam int unsigned PORT_A    = 0;
    localparam int unsigned PORT_B    = 1;
    localparam int unsigned PORT_C    = 2;
    localparam int unsigned NUM_PORTS = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FWD  = 2'b01,
        ST_DROP = 2'b10
    } state_t;

    function automatic logic isRoutableHead(input logic [1:0] flitType, input logic [1:0] dest);
        return (flitType == FT_HEAD) && (dest != DEST_INV);
    endfunction

endpackage

// File: rtl/flit_out_reg.sv
// One-entry valid/ready output register; a load while draining keeps it full with new data.
module flit_out_reg #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] loadData,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         canLoad
);

    assign canLoad = ~valid | ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= loadData;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/flit_demux1x3.sv
// Routes packets from an FWFT FIFO to one of three output registers by head destination.
// Define FLIT_DEMUX_ERRCNT_EN to add the saturating ErrCnt_o protocol-error counter.
module flit_demux1x3
    import flit_pkg::*;
#(
    parameter int unsigned FLIT_W   = 32,
    parameter int unsigned DEST_LSB = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              FifoEmpty_i,
    input  logic [FLIT_W-1:0] FifoRdData_i,
    output logic              FifoRd_o,
    output logic              ValidA_o,
    output logic              ValidB_o,
    output logic              ValidC_o,
    output logic [FLIT_W-1:0] DataA_o,
    output logic [FLIT_W-1:0] DataB_o,
    output logic [FLIT_W-1:0] DataC_o,
    input  logic              ReadyA_i,
    input  logic              ReadyB_i,
    input  logic              ReadyC_i
`ifdef FLIT_DEMUX_ERRCNT_EN
    ,
    output logic [7:0]        ErrCnt_o
`endif
);

    state_t     state;
    state_t     nextOnPop;
    logic [1:0] route;
    logic [1:0] target;
    logic [1:0] flitType;
    logic [1:0] flitDest;
    logic       popReq;
    logic       fwdFlit;
    logic       targetCanLoad;
    logic       pop;
    logic [2:0] canLoad;
    logic [2:0] load;

    assign flitType = FifoRdData_i[FLIT_W-1 -: 2];
    assign flitDest = FifoRdData_i[DEST_LSB+1:DEST_LSB];

    always_comb begin
        target = (state == ST_IDLE) ? flitDest : route;
        case (target)
            DEST_A:  targetCanLoad = canLoad[PORT_A];
            DEST_B:  targetCanLoad = canLoad[PORT_B];
            default: targetCanLoad = canLoad[PORT_C];
        endcase
    end

    always_comb begin
        popReq    = 1'b0;
        fwdFlit   = 1'b0;
        nextOnPop = state;
        case (state)
            ST_IDLE: begin
                if (isRoutableHead(flitType, flitDest)) begin
                    fwdFlit   = 1'b1;
                    popReq    = targetCanLoad;
                    nextOnPop = ST_FWD;
                end else if (flitType == FT_HEAD) begin
                    popReq    = 1'b1;
                    nextOnPop = ST_DROP;
                end else begin
                    popReq    = 1'b1;
                end
            end
            ST_FWD: begin
                fwdFlit   = 1'b1;
                popReq    = targetCanLoad;
                nextOnPop = (flitType == FT_TAIL) ? ST_IDLE : ST_FWD;
            end
            ST_DROP: begin
                popReq    = 1'b1;
                nextOnPop = (flitType == FT_TAIL) ? ST_IDLE : ST_DROP;
            end
            default: begin
                popReq    = 1'b0;
                nextOnPop = ST_IDLE;
            end
        endcase
    end

    // Reset gates the pop so nothing is consumed while the datapath is being cleared.
    assign pop      = popReq & ~FifoEmpty_i & ~rst;
    assign FifoRd_o = pop;

    assign load[PORT_A] = pop & fwdFlit & (target == DEST_A);
    assign load[PORT_B] = pop & fwdFlit & (target == DEST_B);
    assign load[PORT_C] = pop & fwdFlit & (target == DEST_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            route <= DEST_A;
        end else if (pop) begin
            state <= nextOnPop;
            if (state == ST_IDLE && fwdFlit)
                route <= flitDest;
        end
    end

    flit_out_reg #(.W(FLIT_W)) uRegA (
        .clk(clk), .rst(rst), .load(load[PORT_A]), .loadData(FifoRdData_i),
        .ready(ReadyA_i), .valid(ValidA_o), .data(DataA_o), .canLoad(canLoad[PORT_A])
    );

    flit_out_reg #(.W(FLIT_W)) uRegB (
        .clk(clk), .rst(rst), .load(load[PORT_B]), .loadData(FifoRdData_i),
        .ready(ReadyB_i), .valid(ValidB_o), .data(DataB_o), .canLoad(canLoad[PORT_B])
    );

    flit_out_reg #(.W(FLIT_W)) uRegC (
        .clk(clk), .rst(rst), .load(load[PORT_C]), .loadData(FifoRdData_i),
        .ready(ReadyC_i), .valid(ValidC_o), .data(DataC_o), .canLoad(canLoad[PORT_C])
    );

`ifdef FLIT_DEMUX_ERRCNT_EN
    logic       errEvent;
    logic [7:0] errCnt;

    assign errEvent = (state == ST_IDLE) & ~isRoutableHead(flitType, flitDest);

    always_ff @(posedge clk) begin
        if (rst)
            errCnt <= '0;
        else if (pop && errEvent && errCnt != 8'hFF)
            errCnt <= errCnt + 8'd1;
    end

    assign ErrCnt_o = errCnt;
`endif

endmodule

// File: tb/tb_flit_demux1x3.sv
// Scoreboard bench for flit_demux1x3: directed packets feed a FIFO model, a monitor checks each port handshake.
module tb_flit_demux1x3;

    logic        clk = 1'b0;
    logic        rst;
    logic        FifoEmpty_i;
    logic [31:0] FifoRdData_i;
    logic        FifoRd_o;
    logic        ValidA_o, ValidB_o, ValidC_o;
    logic [31:0] DataA_o, DataB_o, DataC_o;
    logic        ReadyA_i, ReadyB_i, ReadyC_i;
`ifdef FLIT_DEMUX_ERRCNT_EN
    logic [7:0]  ErrCnt_o;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    int          cycle = 0;
    logic [31:0] fifoQ[$];
    logic [31:0] expA[$], expB[$], expC[$];
    int          bTimes[$];
    logic        popPending = 1'b0;

    flit_demux1x3 #(.FLIT_W(32), .DEST_LSB(28)) dut (
        .clk(clk), .rst(rst),
        .FifoEmpty_i(FifoEmpty_i), .FifoRdData_i(FifoRdData_i), .FifoRd_o(FifoRd_o),
        .ValidA_o(ValidA_o), .ValidB_o(ValidB_o), .ValidC_o(ValidC_o),
        .DataA_o(DataA_o), .DataB_o(DataB_o), .DataC_o(DataC_o),
        .ReadyA_i(ReadyA_i), .ReadyB_i(ReadyB_i), .ReadyC_i(ReadyC_i)
`ifdef FLIT_DEMUX_ERRCNT_EN
        , .ErrCnt_o(ErrCnt_o)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // FWFT FIFO model: pop decided from FifoRd_o sampled mid-cycle, head refreshed after the edge.
    always @(negedge clk) popPending = FifoRd_o;
    always @(posedge clk) begin
        #1;
        if (popPending && fifoQ.size() != 0) void'(fifoQ.pop_front());
        popPending = 1'b0;
        #1;
        FifoEmpty_i  = (fifoQ.size() == 0);
        FifoRdData_i = FifoEmpty_i ? 32'hDEAD_BEEF : fifoQ[0];
    end

    // Monitor: every handshake on a port must match the next expected flit for that port.
    always @(negedge clk) begin
        if (!rst) begin
            if (ValidA_o && ReadyA_i) begin
                if (expA.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL portA unexpected flit: got %h, required none", DataA_o);
                end else check("portA", DataA_o, expA.pop_front());
            end
            if (ValidB_o && ReadyB_i) begin
                bTimes.push_back(cycle);
                if (expB.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL portB unexpected flit: got %h, required none", DataB_o);
                end else check("portB", DataB_o, expB.pop_front());
            end
            if (ValidC_o && ReadyC_i) begin
                if (expC.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL portC unexpected flit: got %h, required none", DataC_o);
                end else check("portC", DataC_o, expC.pop_front());
            end
            if (FifoEmpty_i) check("rdWhenEmpty", {31'b0, FifoRd_o}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        fifoQ.push_back(w);
    endtask

    task automatic waitIdle(input string name, input int maxC);
        int n = 0;
        while ((fifoQ.size() != 0 || expA.size() != 0 || expB.size() != 0 || expC.size() != 0) && n < maxC) begin
            tick();
            n++;
        end
        check({"drainTimeout_", name}, {31'b0, n < maxC}, 32'd1);
        tick();
        tick();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        ReadyA_i = 1'b1; ReadyB_i = 1'b1; ReadyC_i = 1'b1;
        FifoEmpty_i = 1'b1; FifoRdData_i = '0;

        // FIFO already holds a packet during reset: nothing may be popped.
        push(32'h0000_0055); push(32'hC000_0056);
        expA.push_back(32'h0000_0055); expA.push_back(32'hC000_0056);
        tick(); tick();
        @(negedge clk);
        check("rst_ValidA", {31'b0, ValidA_o}, 32'd0);
        check("rst_ValidB", {31'b0, ValidB_o}, 32'd0);
        check("rst_ValidC", {31'b0, ValidC_o}, 32'd0);
        check("rst_DataA", DataA_o, 32'd0);
        check("rst_DataB", DataB_o, 32'd0);
        check("rst_DataC", DataC_o, 32'd0);
        check("rst_FifoRd", {31'b0, FifoRd_o}, 32'd0);
        check("rst_FifoNotEmpty", {31'b0, FifoEmpty_i}, 32'd0);
`ifdef FLIT_DEMUX_ERRCNT_EN
        check("rst_ErrCnt", {24'b0, ErrCnt_o}, 32'd0);
`endif
        tick();
        rst = 1'b0;
        waitIdle("boot", 50);

        // Four-flit packet to B streams on consecutive cycles.
        bTimes.delete();
        push(32'h1000_0001); push(32'h4000_0002); push(32'h8000_0003); push(32'hC000_0004);
        expB.push_back(32'h1000_0001); expB.push_back(32'h4000_0002);
        expB.push_back(32'h8000_0003); expB.push_back(32'hC000_0004);
        waitIdle("pktB", 50);
        check("pktB_count", bTimes.size(), 32'd4);
        if (bTimes.size() == 4) check("pktB_consecutive", bTimes[3] - bTimes[0], 32'd3);

        // Packet to C held off by ReadyC_i low for five cycles.
        ReadyC_i = 1'b0;
        push(32'h2000_0007); push(32'h4000_0008); push(32'hC000_0009);
        expC.push_back(32'h2000_0007); expC.push_back(32'h4000_0008); expC.push_back(32'hC000_0009);
        n = 0;
        while (!ValidC_o && n < 20) begin tick(); n++; end
        check("stallC_validTimeout", {31'b0, n < 20}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            check("stallC_Valid", {31'b0, ValidC_o}, 32'd1);
            check("stallC_Data", DataC_o, 32'h2000_0007);
            check("stallC_FifoRd", {31'b0, FifoRd_o}, 32'd0);
        end
        tick();
        ReadyC_i = 1'b1;
        waitIdle("stallC", 50);

        // Invalid-destination packet is dropped whole; next packet goes to A.
        push(32'h3000_0010); push(32'h4000_0011); push(32'hC000_0012);
        push(32'h0000_0020); push(32'hC000_0021);
        expA.push_back(32'h0000_0020); expA.push_back(32'hC000_0021);
        waitIdle("drop", 50);
`ifdef FLIT_DEMUX_ERRCNT_EN
        check("drop_ErrCnt", {24'b0, ErrCnt_o}, 32'd1);
`endif

        // Stray body flit in IDLE is discarded; following head to B routes normally.
        push(32'h4000_0001); push(32'h1000_0030); push(32'hC000_0031);
        expB.push_back(32'h1000_0030); expB.push_back(32'hC000_0031);
        waitIdle("strayBody", 50);
`ifdef FLIT_DEMUX_ERRCNT_EN
        check("stray_ErrCnt", {24'b0, ErrCnt_o}, 32'd2);
`endif

        // Reset in the middle of a packet to A.
        ReadyA_i = 1'b0;
        push(32'h0000_0040); push(32'h4000_0041); push(32'h8000_0042);
        n = 0;
        while (!ValidA_o && n < 20) begin tick(); n++; end
        check("midRst_ValidBefore", {31'b0, ValidA_o}, 32'd1);
        rst = 1'b1;
        fifoQ.delete();
        tick();
        @(negedge clk);
        check("midRst_ValidA", {31'b0, ValidA_o}, 32'd0);
        check("midRst_DataA", DataA_o, 32'd0);
        check("midRst_FifoRd", {31'b0, FifoRd_o}, 32'd0);
`ifdef FLIT_DEMUX_ERRCNT_EN
        check("midRst_ErrCnt", {24'b0, ErrCnt_o}, 32'd0);
`endif
        tick();
        rst = 1'b0;
        ReadyA_i = 1'b1;
        push(32'h1000_0050); push(32'hC000_0051);
        expB.push_back(32'h1000_0050); expB.push_back(32'hC000_0051);
        waitIdle("afterRst", 50);

        // 300 stray body flits, then a packet to C.
        for (int i = 0; i < 300; i++) push(32'h8000_0000 | i);
        push(32'h2000_0060); push(32'hC000_0061);
        expC.push_back(32'h2000_0060); expC.push_back(32'hC000_0061);
        waitIdle("errSat", 400);
`ifdef FLIT_DEMUX_ERRCNT_EN
        check("errSat_ErrCnt", {24'b0, ErrCnt_o}, 32'd255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/flit_demux1x3.md
FLIT_DEMUX1X3 -- requirements
Module: flit_demux1x3

Interface
REQ-001 SHALL have parameter FLIT_W, default 32, flit width in bits.
REQ-002 SHALL have parameter DEST_LSB, default 28, LSB of the 2-bit destination field in head flits.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port FifoEmpty_i, input, 1: upstream FWFT FIFO empty.
REQ-006 SHALL have port FifoRdData_i, input, FLIT_W: FIFO head word, valid whenever FifoEmpty_i=0.
REQ-007 SHALL have port FifoRd_o, output, 1: pop FIFO this cycle.
REQ-008 SHALL have ports ValidA_o/ValidB_o/ValidC_o, output, 1 each: output flit valid.
REQ-009 SHALL have ports DataA_o/DataB_o/DataC_o, output, FLIT_W each: output flit.
REQ-010 SHALL have ports ReadyA_i/ReadyB_i/ReadyC_i, input, 1 each: downstream accept.
REQ-011 SHALL have port ErrCnt_o, output, 8: protocol-error count (present only per REQ-030).

Function
REQ-012 SHALL decode flit type from bits [FLIT_W-1:FLIT_W-2]: 00 head, 11 tail, 01/10 body.
REQ-013 SHALL decode head destination from [DEST_LSB+1:DEST_LSB]: 00 A, 01 B, 10 C, 11 invalid.
REQ-014 SHALL implement FSM states IDLE, FWD, DROP; reset state IDLE.
REQ-015 IDLE + popped head with valid dest: latch route, go FWD; head forwarded to that port.
REQ-016 IDLE + popped head with dest 11: go DROP; head discarded; error event.
REQ-017 IDLE + popped non-head flit: discard flit, stay IDLE, error event.
REQ-018 FWD: every popped flit forwarded to latched port; popped tail returns to IDLE.
REQ-019 DROP: pop whenever FifoEmpty_i=0, discard; popped tail returns to IDLE.
REQ-020 Each port SHALL own a one-entry output register; Valid_o = register full.
REQ-021 Register drains when Valid_o & Ready_i; load and drain in the same cycle keeps it full with new data.
REQ-022 FifoRd_o = ~FifoEmpty_i & (DROP | IDLE-discard | target register empty | target draining this cycle).
REQ-023 Latency: flit popped in cycle N is on Valid_o/Data_o in cycle N+1; sustained 1 flit/cycle with Ready_i held high.
REQ-024 Data_o SHALL hold stable while Valid_o=1 and Ready_i=0.
REQ-025 Only the routed port SHALL ever load; the other two registers are untouched.
REQ-026 FifoRd_o SHALL never assert while FifoEmpty_i=1.
REQ-027 A head in IDLE SHALL pop even if its target register is full-and-stalled only when REQ-022 allows; otherwise it waits, FSM stays IDLE.

Reset
REQ-028 On rst: FSM IDLE, all Valid_o=0, all Data_o=0, route=A, ErrCnt_o=0, FifoRd_o=0 in the reset cycle.
REQ-029 Reset mid-packet SHALL discard register contents and packet state; next flit is expected to be a head.

Configuration
REQ-030 Macro FLIT_DEMUX_ERRCNT_EN defined: ErrCnt_o present, +1 per error event, saturating at 255.
REQ-031 Macro FLIT_DEMUX_ERRCNT_EN undefined: no ErrCnt_o port, no counter; error events still discard per REQ-016/017.

Structure
REQ-032 Shared package flit_pkg SHALL hold flit-type constants, dest field encodings, port index constants, FSM state enum.
REQ-033 SHALL instantiate sub-module flit_out_reg (one-entry valid/ready register) three times.

Verification
REQ-034 Head dest 01 + 2 body + tail, all Ready=1 -> 4 flits on B on consecutive cycles starting 1 cycle after first pop; A/C Valid stay 0.
REQ-035 Packet to C with ReadyC_i=0 for 5 cycles -> ValidC_o=1, DataC_o stable, FifoRd_o=0 until ReadyC_i=1.
REQ-036 Head dest 11 + body + tail, then head to A -> three flits dropped, ErrCnt_o=1, next packet on A.
REQ-037 Body flit 0x4000_0001 arriving in IDLE -> discarded, ErrCnt_o +1, following head routed normally.
REQ-038 Assert rst mid-packet on A -> next cycle ValidA_o=0, FSM IDLE; subsequent head to B routes to B.
REQ-039 300 error events with FLIT_DEMUX_ERRCNT_EN -> ErrCnt_o=255.
